// File: rtl/alarm_mode_ctrl.sv
// alarm_mode_ctrl: mode sequencer and alarm controller for the wall clock.
// Steps through RUN / set-time / set-alarm modes on the center button and
// emits one-cycle hour/minute adjust strobes to the time counters. It also
// edits the stored alarm time, and handles alarm compare, ring, timeout and
// (optionally) snooze.
//
// Optional feature macro: ALARM_SNOOZE_EN (snooze on up/down while ringing).
//
// Ports:
//   clk_i, reset_i           clock, synchronous active-high reset
//   tick_1s_i                one-cycle pulse per second
//   up/down/center_pulse_i   debounced one-cycle button presses
//   cur_hour/min/sec_i       running time of day
//   state_o                  RUN=0 ST_H=1 ST_M=2 SA_H=3 SA_M=4 RING=5
//   inc/dec_hour/min_o       one-cycle adjust strobes to the time counters
//   alarm_hour/min_o         stored alarm time
//   alarm_armed_o            alarm enabled
//   ringing_o                high while ringing
//   disp_sel_o               0 = show time, 1 = show alarm
//   blink_field_o            0 = none, 1 = hours, 2 = minutes
module alarm_mode_ctrl #(
   parameter int unsigned RING_SECS  = 60,
   parameter int unsigned SNOOZE_MIN = 5
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       tick_1s_i,
   input  logic       up_pulse_i,
   input  logic       down_pulse_i,
   input  logic       center_pulse_i,
   input  logic [4:0] cur_hour_i,
   input  logic [5:0] cur_min_i,
   input  logic [5:0] cur_sec_i,
   output logic [2:0] state_o,
   output logic       inc_hour_o,
   output logic       dec_hour_o,
   output logic       inc_min_o,
   output logic       dec_min_o,
   output logic [4:0] alarm_hour_o,
   output logic [5:0] alarm_min_o,
   output logic       alarm_armed_o,
   output logic       ringing_o,
   output logic       disp_sel_o,
   output logic [1:0] blink_field_o
);

   localparam int unsigned HOUR_W = 5;
   localparam int unsigned MIN_W  = 6;
   localparam int unsigned CNT_W  = 8;

   // Reject out-of-range parameters at elaboration.
   if (RING_SECS < 1 || RING_SECS > 255 || SNOOZE_MIN < 1 || SNOOZE_MIN > 59) begin : g_param_check
      $error("alarm_mode_ctrl: RING_SECS or SNOOZE_MIN out of range");
   end

   typedef enum logic [2:0] {
      S_RUN  = 3'd0,
      S_ST_H = 3'd1,
      S_ST_M = 3'd2,
      S_SA_H = 3'd3,
      S_SA_M = 3'd4,
      S_RING = 3'd5
   } state_e;

   state_e            state_q, state_d;
   logic              inc_hour_q, inc_hour_d, dec_hour_q, dec_hour_d;
   logic              inc_min_q, inc_min_d, dec_min_q, dec_min_d;
   logic [HOUR_W-1:0] alarm_hour_q, alarm_hour_d;
   logic [MIN_W-1:0]  alarm_min_q, alarm_min_d;
   logic              armed_q, armed_d;
   logic              fired_q, fired_d;
   logic [CNT_W-1:0]  ring_cnt_q, ring_cnt_d;

   // Button qualification: center beats up/down, up+down together cancel.
   logic up_c, dn_c, ctr_c;
   assign ctr_c = center_pulse_i;
   assign up_c  = up_pulse_i & ~down_pulse_i & ~center_pulse_i;
   assign dn_c  = down_pulse_i & ~up_pulse_i & ~center_pulse_i;

   logic alarm_match_c, snz_match_c, trig_c;
   assign alarm_match_c = (cur_hour_i == alarm_hour_q) && (cur_min_i == alarm_min_q);

`ifdef ALARM_SNOOZE_EN
   logic              snz_pend_q, snz_pend_d;
   logic [HOUR_W-1:0] snz_hour_q, snz_hour_d, match_hour_q, match_hour_d;
   logic [MIN_W-1:0]  snz_min_q, snz_min_d, match_min_q, match_min_d;
   logic [HOUR_W-1:0] snz_next_hour_c;
   logic [MIN_W-1:0]  snz_next_min_c;
   logic [MIN_W:0]    snz_sum_c;

   assign snz_match_c = snz_pend_q && (cur_hour_i == snz_hour_q) && (cur_min_i == snz_min_q);

   // Snooze time = time that started this ring + SNOOZE_MIN, wrapping into the hour.
   always_comb begin
      snz_sum_c       = (MIN_W+1)'(match_min_q) + (MIN_W+1)'(SNOOZE_MIN);
      snz_next_min_c  = MIN_W'(snz_sum_c);
      snz_next_hour_c = match_hour_q;
      if (snz_sum_c >= (MIN_W+1)'(60)) begin
         snz_next_min_c  = MIN_W'(snz_sum_c - (MIN_W+1)'(60));
         snz_next_hour_c = (match_hour_q == HOUR_W'(23)) ? '0 : match_hour_q + HOUR_W'(1);
      end
   end
`else
   assign snz_match_c = 1'b0;
`endif

   assign trig_c = (state_q == S_RUN) && armed_q && (cur_sec_i == '0) && !fired_q &&
                   (alarm_match_c || snz_match_c);

   // Next-state and register-update logic.
   always_comb begin
      state_d      = state_q;
      inc_hour_d   = 1'b0;
      dec_hour_d   = 1'b0;
      inc_min_d    = 1'b0;
      dec_min_d    = 1'b0;
      alarm_hour_d = alarm_hour_q;
      alarm_min_d  = alarm_min_q;
      armed_d      = armed_q;
      fired_d      = fired_q;
      ring_cnt_d   = ring_cnt_q;
`ifdef ALARM_SNOOZE_EN
      snz_pend_d   = snz_pend_q;
      snz_hour_d   = snz_hour_q;
      snz_min_d    = snz_min_q;
      match_hour_d = match_hour_q;
      match_min_d  = match_min_q;
`endif
      // Leaving the alarm minute re-enables the trigger.
      if (fired_q && (cur_min_i != alarm_min_q)) fired_d = 1'b0;

      unique case (state_q)
         S_RUN: begin
            if (trig_c) begin
               state_d    = S_RING;
               fired_d    = 1'b1;
               ring_cnt_d = '0;
`ifdef ALARM_SNOOZE_EN
               snz_pend_d   = 1'b0;
               match_hour_d = cur_hour_i;
               match_min_d  = cur_min_i;
`endif
            end else if (ctr_c) begin
               state_d = S_ST_H;
            end else if (up_c) begin
               armed_d = ~armed_q;
`ifdef ALARM_SNOOZE_EN
               if (armed_q) snz_pend_d = 1'b0;
`endif
            end
         end
         S_ST_H: begin
            if (ctr_c) state_d = S_ST_M;
            inc_hour_d = up_c;
            dec_hour_d = dn_c;
         end
         S_ST_M: begin
            if (ctr_c) state_d = S_SA_H;
            inc_min_d = up_c;
            dec_min_d = dn_c;
         end
         S_SA_H: begin
            if (ctr_c) state_d = S_SA_M;
            else if (up_c) alarm_hour_d = (alarm_hour_q == HOUR_W'(23)) ? '0 : alarm_hour_q + HOUR_W'(1);
            else if (dn_c) alarm_hour_d = (alarm_hour_q == '0) ? HOUR_W'(23) : alarm_hour_q - HOUR_W'(1);
         end
         S_SA_M: begin
            if (ctr_c) state_d = S_RUN;
            else if (up_c) alarm_min_d = (alarm_min_q == MIN_W'(59)) ? '0 : alarm_min_q + MIN_W'(1);
            else if (dn_c) alarm_min_d = (alarm_min_q == '0) ? MIN_W'(59) : alarm_min_q - MIN_W'(1);
         end
         S_RING: begin
            if (ctr_c) begin
               state_d = S_RUN;
`ifdef ALARM_SNOOZE_EN
               snz_pend_d = 1'b0;
`endif
            end else if (up_c || dn_c) begin
               state_d = S_RUN;
`ifdef ALARM_SNOOZE_EN
               snz_pend_d = 1'b1;
               snz_hour_d = snz_next_hour_c;
               snz_min_d  = snz_next_min_c;
`endif
            end else if (tick_1s_i) begin
               // Timeout on the RING_SECS-th tick behaves as a dismiss.
               if (ring_cnt_q == CNT_W'(RING_SECS - 1)) begin
                  state_d = S_RUN;
`ifdef ALARM_SNOOZE_EN
                  snz_pend_d = 1'b0;
`endif
               end else begin
                  ring_cnt_d = ring_cnt_q + CNT_W'(1);
               end
            end
         end
         default: state_d = S_RUN;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q      <= S_RUN;
         inc_hour_q   <= 1'b0;
         dec_hour_q   <= 1'b0;
         inc_min_q    <= 1'b0;
         dec_min_q    <= 1'b0;
         alarm_hour_q <= '0;
         alarm_min_q  <= '0;
         armed_q      <= 1'b0;
         fired_q      <= 1'b0;
         ring_cnt_q   <= '0;
`ifdef ALARM_SNOOZE_EN
         snz_pend_q   <= 1'b0;
         snz_hour_q   <= '0;
         snz_min_q    <= '0;
         match_hour_q <= '0;
         match_min_q  <= '0;
`endif
      end else begin
         state_q      <= state_d;
         inc_hour_q   <= inc_hour_d;
         dec_hour_q   <= dec_hour_d;
         inc_min_q    <= inc_min_d;
         dec_min_q    <= dec_min_d;
         alarm_hour_q <= alarm_hour_d;
         alarm_min_q  <= alarm_min_d;
         armed_q      <= armed_d;
         fired_q      <= fired_d;
         ring_cnt_q   <= ring_cnt_d;
`ifdef ALARM_SNOOZE_EN
         snz_pend_q   <= snz_pend_d;
         snz_hour_q   <= snz_hour_d;
         snz_min_q    <= snz_min_d;
         match_hour_q <= match_hour_d;
         match_min_q  <= match_min_d;
`endif
      end
   end

   // Display decode straight off the state register.
   assign state_o       = state_q;
   assign inc_hour_o    = inc_hour_q;
   assign dec_hour_o    = dec_hour_q;
   assign inc_min_o     = inc_min_q;
   assign dec_min_o     = dec_min_q;
   assign alarm_hour_o  = alarm_hour_q;
   assign alarm_min_o   = alarm_min_q;
   assign alarm_armed_o = armed_q;
   assign ringing_o     = (state_q == S_RING);
   assign disp_sel_o    = (state_q == S_SA_H) || (state_q == S_SA_M);
   assign blink_field_o = ((state_q == S_ST_H) || (state_q == S_SA_H)) ? 2'd1 :
                          ((state_q == S_ST_M) || (state_q == S_SA_M)) ? 2'd2 : 2'd0;

endmodule

// File: tb/tb_alarm_mode_ctrl.sv
// Testbench for alarm_mode_ctrl: randomized edit-mode traffic against a
// behavioural model plus directed alarm, timeout, snooze and reset scenarios.
module tb_alarm_mode_ctrl;

   localparam int unsigned RS  = 8;
   localparam int unsigned SNZ = 5;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       tick = 1'b0, up = 1'b0, down = 1'b0, center = 1'b0;
   logic [4:0] hr = 5'd12;
   logic [5:0] mn = 6'd0, sc = 6'd17;
   logic [2:0] st;
   logic       inc_h, dec_h, inc_m, dec_m;
   logic [4:0] al_h;
   logic [5:0] al_m;
   logic       armed, ringing, disp;
   logic [1:0] blink;

   int checks = 0;
   int failures = 0;

   // Behavioural model of the non-ringing modes.
   int m_mode = 0, m_armed = 0, m_ah = 0, m_am = 0;
   int e_ih = 0, e_dh = 0, e_im = 0, e_dm = 0;

`ifdef ALARM_SNOOZE_EN
   localparam int SNOOZE_ON = 1;
`else
   localparam int SNOOZE_ON = 0;
`endif

   alarm_mode_ctrl #(.RING_SECS(RS), .SNOOZE_MIN(SNZ)) dut (
      .clk_i(clk), .reset_i(reset), .tick_1s_i(tick),
      .up_pulse_i(up), .down_pulse_i(down), .center_pulse_i(center),
      .cur_hour_i(hr), .cur_min_i(mn), .cur_sec_i(sc),
      .state_o(st), .inc_hour_o(inc_h), .dec_hour_o(dec_h),
      .inc_min_o(inc_m), .dec_min_o(dec_m),
      .alarm_hour_o(al_h), .alarm_min_o(al_m), .alarm_armed_o(armed),
      .ringing_o(ringing), .disp_sel_o(disp), .blink_field_o(blink)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic cyc();
      @(posedge clk); #1;
   endtask

   task automatic model_reset();
      m_mode = 0; m_armed = 0; m_ah = 0; m_am = 0;
   endtask

   task automatic model_step(input int u, input int d, input int c);
      e_ih = 0; e_dh = 0; e_im = 0; e_dm = 0;
      if (c != 0) m_mode = (m_mode + 1) % 5;
      else if ((u ^ d) != 0) begin
         case (m_mode)
            0: if (u != 0) m_armed = 1 - m_armed;
            1: begin e_ih = u; e_dh = d; end
            2: begin e_im = u; e_dm = d; end
            3: m_ah = (m_ah + ((u != 0) ? 1 : 23)) % 24;
            default: m_am = (m_am + ((u != 0) ? 1 : 59)) % 60;
         endcase
      end
   endtask

   task automatic press(input int u, input int d, input int c);
      up = 1'(u); down = 1'(d); center = 1'(c);
      cyc();
      up = 1'b0; down = 1'b0; center = 1'b0;
      model_step(u, d, c);
   endtask

   // Button pulse while ringing: not tracked by the edit-mode model.
   task automatic pulse_raw(input int u, input int d, input int c);
      up = 1'(u); down = 1'(d); center = 1'(c);
      cyc();
      up = 1'b0; down = 1'b0; center = 1'b0;
   endtask

   task automatic goto_mode(input int t);
      for (int i = 0; i < 5 && m_mode != t; i++) press(0, 0, 1);
   endtask

   task automatic set_time(input int h, input int m, input int s);
      hr = 5'(h); mn = 6'(m); sc = 6'(s);
      cyc();
   endtask

   task automatic set_alarm(input int h, input int m);
      goto_mode(3);
      repeat ((h + 24 - m_ah) % 24) press(1, 0, 0);
      goto_mode(4);
      repeat ((m + 60 - m_am) % 60) press(1, 0, 0);
      goto_mode(0);
   endtask

   task automatic arm();
      goto_mode(0);
      if (m_armed == 0) press(1, 0, 0);
   endtask

   task automatic test_reset();
      reset = 1'b1; cyc(); cyc(); reset = 1'b0;
      model_reset();
      checks++; if (st !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", st); end
      checks++; if ({inc_h, dec_h, inc_m, dec_m} !== 4'b0) begin failures++; $display("FAIL reset_strobes got=%b exp=0000", {inc_h, dec_h, inc_m, dec_m}); end
      checks++; if (al_h !== 5'd0 || al_m !== 6'd0) begin failures++; $display("FAIL reset_alarm got=%0d:%0d exp=0:0", al_h, al_m); end
      checks++; if ({armed, ringing, disp, blink} !== 5'b0) begin failures++; $display("FAIL reset_flags got=%b exp=00000", {armed, ringing, disp, blink}); end
   endtask

   task automatic test_mode_cycle();
      int es[5] = '{1, 2, 3, 4, 0};
      int ed[5] = '{0, 0, 1, 1, 0};
      int eb[5] = '{1, 2, 1, 2, 0};
      for (int i = 0; i < 5; i++) begin
         press(0, 0, 1);
         checks++; if (int'(st) != es[i]) begin failures++; $display("FAIL mode_state[%0d] got=%0d exp=%0d", i, st, es[i]); end
         checks++; if (int'(disp) != ed[i]) begin failures++; $display("FAIL mode_disp[%0d] got=%0d exp=%0d", i, disp, ed[i]); end
         checks++; if (int'(blink) != eb[i]) begin failures++; $display("FAIL mode_blink[%0d] got=%0d exp=%0d", i, blink, eb[i]); end
         repeat (9) cyc();
      end
   endtask

   task automatic test_alarm_wrap();
      goto_mode(3);
      press(0, 1, 0);
      checks++; if (al_h !== 5'd23) begin failures++; $display("FAIL wrap_hour_down got=%0d exp=23", al_h); end
      press(1, 0, 0);
      checks++; if (al_h !== 5'd0) begin failures++; $display("FAIL wrap_hour_up got=%0d exp=0", al_h); end
      goto_mode(4);
      press(0, 1, 0);
      checks++; if (al_m !== 6'd59) begin failures++; $display("FAIL wrap_min_down got=%0d exp=59", al_m); end
      press(1, 1, 0);
      checks++; if (al_m !== 6'd59) begin failures++; $display("FAIL updown_cancel got=%0d exp=59", al_m); end
      press(1, 0, 0);
      checks++; if (al_m !== 6'd0) begin failures++; $display("FAIL wrap_min_up got=%0d exp=0", al_m); end
      goto_mode(0);
   endtask

   task automatic test_random_edit();
      int u, d, c;
      set_time(12, 0, 17);
      for (int i = 0; i < 200; i++) begin
         c = ($urandom_range(0, 9) == 0) ? 1 : 0;
         u = int'($urandom_range(0, 1));
         d = int'($urandom_range(0, 1));
         press(u, d, c);
         checks++; if (int'(st) != m_mode) begin failures++; $display("FAIL rnd_state[%0d] got=%0d exp=%0d", i, st, m_mode); end
         checks++; if ({inc_h, dec_h, inc_m, dec_m} !== {1'(e_ih), 1'(e_dh), 1'(e_im), 1'(e_dm)}) begin
            failures++; $display("FAIL rnd_strobes[%0d] got=%b exp=%b", i, {inc_h, dec_h, inc_m, dec_m}, {1'(e_ih), 1'(e_dh), 1'(e_im), 1'(e_dm)});
         end
         checks++; if (int'(al_h) != m_ah || int'(al_m) != m_am) begin failures++; $display("FAIL rnd_alarm[%0d] got=%0d:%0d exp=%0d:%0d", i, al_h, al_m, m_ah, m_am); end
         checks++; if (int'(armed) != m_armed) begin failures++; $display("FAIL rnd_armed[%0d] got=%0d exp=%0d", i, armed, m_armed); end
         cyc();
         checks++; if ({inc_h, dec_h, inc_m, dec_m} !== 4'b0) begin failures++; $display("FAIL rnd_strobe_len[%0d] got=%b exp=0000", i, {inc_h, dec_h, inc_m, dec_m}); end
      end
      goto_mode(0);
   endtask

   task automatic test_alarm_trigger();
      int h, m;
      set_time(12, 0, 17);
      arm();
      set_alarm(7, 30);
      set_time(7, 29, 59);
      checks++; if (st !== 3'd0) begin failures++; $display("FAIL trig_early got=%0d exp=0", st); end
      set_time(7, 30, 0);
      checks++; if (st !== 3'd5 || ringing !== 1'b1) begin failures++; $display("FAIL trig_ring got=%0d/%0d exp=5/1", st, ringing); end
      pulse_raw(0, 0, 1);
      checks++; if (st !== 3'd0 || ringing !== 1'b0) begin failures++; $display("FAIL trig_dismiss got=%0d/%0d exp=0/0", st, ringing); end
      for (int i = 0; i < 5; i++) begin
         cyc();
         checks++; if (st !== 3'd0) begin failures++; $display("FAIL trig_no_rering[%0d] got=%0d exp=0", i, st); end
      end
      for (int k = 0; k < 3; k++) begin
         h = int'($urandom_range(0, 23));
         m = int'($urandom_range(0, 59));
         set_time(12, 0, 17);
         set_alarm(h, m);
         set_time(h, (m + 59) % 60, 59);
         set_time(h, m, 0);
         checks++; if (st !== 3'd5) begin failures++; $display("FAIL trig_rand[%0d] %0d:%0d got=%0d exp=5", k, h, m, st); end
         pulse_raw(0, 0, 1);
      end
   endtask

   task automatic test_ring_timeout();
      set_time(12, 0, 17);
      set_alarm(7, 30);
      set_time(7, 31, 17);
      set_time(7, 30, 0);
      checks++; if (st !== 3'd5) begin failures++; $display("FAIL to_ring got=%0d exp=5", st); end
      for (int k = 1; k <= int'(RS); k++) begin
         tick = 1'b1; cyc(); tick = 1'b0;
         checks++; if (int'(st) != ((k < int'(RS)) ? 5 : 0)) begin failures++; $display("FAIL to_tick[%0d] got=%0d exp=%0d", k, st, (k < int'(RS)) ? 5 : 0); end
         cyc(); cyc();
      end
      repeat (3) cyc();
      checks++; if (st !== 3'd0) begin failures++; $display("FAIL to_no_rering got=%0d exp=0", st); end
      for (int r = 0; r < 2; r++) begin
         set_time(7, 31, 0);
         set_time(7, 30, 0);
         checks++; if (st !== 3'd5) begin failures++; $display("FAIL to_rering[%0d] got=%0d exp=5", r, st); end
         for (int k = 1; k < int'(RS); k++) begin
            tick = 1'b1; cyc(); tick = 1'b0; cyc();
         end
         checks++; if (st !== 3'd5) begin failures++; $display("FAIL to_partial[%0d] got=%0d exp=5", r, st); end
         pulse_raw(0, 0, 1);
         checks++; if (st !== 3'd0) begin failures++; $display("FAIL to_center[%0d] got=%0d exp=0", r, st); end
      end
   endtask

   task automatic test_snooze();
      set_time(12, 0, 17);
      set_alarm(23, 58);
      set_time(23, 57, 30);
      set_time(23, 58, 0);
      checks++; if (st !== 3'd5) begin failures++; $display("FAIL snz_ring got=%0d exp=5", st); end
      pulse_raw(1, 0, 0);
      checks++; if (st !== 3'd0) begin failures++; $display("FAIL snz_leave got=%0d exp=0", st); end
      repeat (3) cyc();
      set_time(0, 2, 59);
      checks++; if (st !== 3'd0) begin failures++; $display("FAIL snz_early got=%0d exp=0", st); end
      set_time(0, 3, 0);
      checks++; if (int'(st) != ((SNOOZE_ON != 0) ? 5 : 0)) begin failures++; $display("FAIL snz_fire got=%0d exp=%0d", st, (SNOOZE_ON != 0) ? 5 : 0); end
      if (st == 3'd5) pulse_raw(0, 0, 1);
      repeat (3) cyc();
      checks++; if (st !== 3'd0) begin failures++; $display("FAIL snz_once got=%0d exp=0", st); end
   endtask

   task automatic test_strobe();
      set_time(12, 0, 17);
      goto_mode(2);
      press(1, 0, 0);
      checks++; if ({inc_h, dec_h, inc_m, dec_m} !== 4'b0010) begin failures++; $display("FAIL strobe_inc_min got=%b exp=0010", {inc_h, dec_h, inc_m, dec_m}); end
      cyc();
      checks++; if (inc_m !== 1'b0) begin failures++; $display("FAIL strobe_inc_len got=%0d exp=0", inc_m); end
      press(0, 1, 1);
      checks++; if (st !== 3'd3 || {inc_h, dec_h, inc_m, dec_m} !== 4'b0) begin failures++; $display("FAIL strobe_center_wins got=%0d/%b exp=3/0000", st, {inc_h, dec_h, inc_m, dec_m}); end
      goto_mode(0);
   endtask

   task automatic test_reset_midway();
      arm();
      set_time(23, 57, 17);
      set_time(23, 58, 0);
      checks++; if (st !== 3'd5) begin failures++; $display("FAIL rst_pre_ring got=%0d exp=5", st); end
      reset = 1'b1; cyc(); reset = 1'b0;
      model_reset();
      checks++; if (st !== 3'd0 || ringing !== 1'b0) begin failures++; $display("FAIL rst_ring got=%0d/%0d exp=0/0", st, ringing); end
      checks++; if (armed !== 1'b0 || al_h !== 5'd0 || al_m !== 6'd0) begin failures++; $display("FAIL rst_regs got=%0d %0d:%0d exp=0 0:0", armed, al_h, al_m); end
      goto_mode(2);
      up = 1'b1; reset = 1'b1; cyc(); up = 1'b0; reset = 1'b0;
      model_reset();
      checks++; if (st !== 3'd0 || {inc_h, dec_h, inc_m, dec_m} !== 4'b0) begin failures++; $display("FAIL rst_edit got=%0d/%b exp=0/0000", st, {inc_h, dec_h, inc_m, dec_m}); end
   endtask

   initial begin
      test_reset();
      test_mode_cycle();
      test_alarm_wrap();
      test_random_edit();
      test_alarm_trigger();
      test_ring_timeout();
      test_snooze();
      test_strobe();
      test_reset_midway();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alarm_mode_ctrl.md
# alarm_mode_ctrl

Mode and alarm controller for the wall clock. It takes the debounced push-button pulses and the running time, and sequences three things:
- the set-time / set-alarm / run modes;
- increment and decrement pulses to the hour and minute counters;
- the alarm compare, ring, timeout and snooze behaviour.

It sits between the button debouncers and the time counters / display path, and is the only block that drives counter adjust strobes.

## Interface
Parameters:
- RING_SECS, 60, number of tick_1s pulses the alarm rings before auto-dismiss (1..255)
- SNOOZE_MIN, 5, snooze delay in minutes (1..59)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- tick_1s  in  1  one-cycle pulse per second from the time base
- up_pulse  in  1  debounced up-button press pulse (one cycle)
- down_pulse  in  1  debounced down-button press pulse (one cycle)
- center_pulse  in  1  debounced center-button press pulse (one cycle)
- cur_hour  in  5  current hour, 0..23
- cur_min  in  6  current minute, 0..59
- cur_sec  in  6  current second, 0..59
- state  out  3  RUN=0, ST_H=1, ST_M=2, SA_H=3, SA_M=4, RING=5
- inc_hour, dec_hour, inc_min, dec_min  out  1 each  one-cycle adjust strobes to the time counters
- alarm_hour  out  5  stored alarm hour
- alarm_min  out  6  stored alarm minute
- alarm_armed  out  1  alarm enabled
- ringing  out  1  high while in RING
- disp_sel  out  1  0 = show time, 1 = show alarm (high in SA_H, SA_M)
- blink_field  out  2  0 = none, 1 = hours, 2 = minutes (field being edited)

## Operation
- center_pulse advances the mode: RUN→ST_H→ST_M→SA_H→SA_M→RUN.
- In RUN, up_pulse toggles alarm_armed. Disarming also clears any pending snooze. down_pulse is ignored in RUN.
- ST_H: up → inc_hour, down → dec_hour. ST_M: up → inc_min, down → dec_min. Wrap is the counters' job.
- SA_H: up/down change alarm_hour modulo 24 (23+1→0, 0−1→23).
- SA_M: up/down change alarm_min modulo 60 (59+1→0, 0−1→59).
- Input priority within one cycle:
  - center_pulse together with up/down: center wins, up/down dropped.
  - up and down together: both dropped.
- Alarm trigger, all of these must hold: state=RUN, alarm_armed=1, cur_sec=0, cur_hour/cur_min equal to alarm_hour/alarm_min, fired=0. Result: go to RING and set fired.
- fired clears when cur_min ≠ alarm_min, so an alarm fires at most once per match minute.
- No alarm trigger in ST_*/SA_*. A missed match is not replayed.
- RING:
  - center_pulse → RUN (dismiss); clears any pending snooze.
  - up_pulse or down_pulse → snooze (see Configuration).
  - Ring counter counts tick_1s. When it reaches RING_SECS, state → RUN, treated as a dismiss.
  - Ring counter clears on every RING entry.

## Timing
- All outputs are registered.
- Adjust strobes and alarm_hour/alarm_min updates appear the cycle after the input pulse. Strobes last exactly one cycle.
- state changes the cycle after center_pulse or the trigger condition.
- ringing, disp_sel and blink_field follow state in the same cycle (decoded from the state register).
- Reset values:
  - state = RUN
  - all strobes = 0
  - alarm_hour = 0, alarm_min = 0
  - alarm_armed = 0, ringing = 0, disp_sel = 0, blink_field = 0
  - fired = 0, snooze pending = 0, ring counter = 0
- A reset asserted in any state, including RING or mid-edit, returns to the above on the next edge. No strobe is emitted.

## Configuration
- ALARM_SNOOZE_EN defined:
  - up/down in RING stores snooze time = current match time + SNOOZE_MIN. Minute wraps mod 60 with carry into hour mod 24 (23:58 + 5 → 00:03).
  - Sets snooze pending and goes to RUN.
  - In RUN with snooze pending and armed, snooze time with cur_sec=0 triggers RING and clears snooze pending. This path uses the same fired-once-per-minute rule.
- ALARM_SNOOZE_EN undefined: up/down in RING act as dismiss, identical to center. No snooze registers are synthesized.

## Test plan
- Reset, then center ×5 with a 10-cycle gap between pulses → state sequence 1,2,3,4,0. disp_sel=1 only at states 3,4; blink_field goes 1,2,1,2,0.
- In SA_H with alarm_hour=23, up → alarm_hour 0. In SA_M with alarm_min=0, down → alarm_min 59. up+down in the same cycle → no change.
- Armed, alarm 07:30, drive time to 07:30:00 → ringing the next cycle. Hold time at 07:30:00 after dismissing with center → no re-ring.
- In RING, apply RING_SECS tick_1s pulses → state=RUN on the cycle after the last tick. Apply RING_SECS−1 ticks then center → RUN, no further ring.
- ALARM_SNOOZE_EN, alarm 23:58, up during RING → RUN. Time 00:03:00 → RING. Without the macro: up dismisses, no ring at 00:03.
- In ST_M, up_pulse → inc_min high for exactly 1 cycle. Assert reset in RING → state 0, ringing 0 on the next edge.
